// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Responder side of the CPU data-memory interface. A single READ or WRITE
//   strobe is accepted in IDLE. The request then spends LATENCY cycles in
//   ACCESS against a DEPTH x DATA_W storage array, and finishes with one DONE
//   cycle. In the DONE cycle BUSYWAIT is low, so the CPU advances its PC.
//
// Ports
//   CLK        in   1       clock, all state changes on posedge
//   RESET      in   1       synchronous, active-low; clears FSM, READDATA and memory
//   READ       in   1       read strobe from the control unit
//   WRITE      in   1       write strobe from the control unit
//   ADDRESS    in   ADDR_W  word address (ALU result)
//   WRITEDATA  in   DATA_W  store data (register file OUT1)
//   READDATA   out  DATA_W  registered load data to the write-back mux
//   BUSYWAIT   out  1       high while a request is being accepted or serviced
module data_memory_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WRITEDATA,
  output logic [DATA_W-1:0] READDATA,
  output logic              BUSYWAIT
);

  localparam int DEPTH = 1 << ADDR_W;
  // The counter only has to hold LATENCY-1. Keep it at least one bit wide so
  // that LATENCY == 1 still elaborates.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               wr_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic [DATA_W-1:0]  data_p0;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic               accept;

  // READ and WRITE together is an illegal request and is never accepted.
  assign accept   = (state == IDLE) && (READ ^ WRITE);
  // BUSYWAIT is combinational, so it rises in the same cycle as the strobe,
  // ahead of the PC edge.
  assign BUSYWAIT = accept || (state == ACCESS);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      READDATA <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        // Request capture: the op, address and data are frozen here, so
        // later changes on these inputs during ACCESS have no effect.
        IDLE: begin
          if (accept) begin
            wr_p0   <= WRITE;
            addr_p0 <= ADDRESS;
            data_p0 <= WRITEDATA;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= ACCESS;
          end
        end
        // Fixed-latency access: commit on the edge where the count reaches zero.
        ACCESS: begin
          if (cnt == '0) begin
            if (wr_p0) begin
              mem[addr_p0] <= data_p0;
            end else begin
              READDATA <= mem[addr_p0];
            end
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        // Release cycle: strobes are ignored, so a strobe the CPU has not yet
        // dropped cannot start a second access.
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int LATENCY = 5;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              READ;
  logic              WRITE;
  logic [ADDR_W-1:0] ADDRESS;
  logic [DATA_W-1:0] WRITEDATA;
  logic [DATA_W-1:0] READDATA;
  logic              BUSYWAIT;

  data_memory_responder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LATENCY(LATENCY)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .READ     (READ),
    .WRITE    (WRITE),
    .ADDRESS  (ADDRESS),
    .WRITEDATA(WRITEDATA),
    .READDATA (READDATA),
    .BUSYWAIT (BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: the memory contents and the last value read.
  logic [DATA_W-1:0] mem_m [1 << ADDR_W];
  logic [DATA_W-1:0] rd_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next active edge. This is where inputs are driven.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1 << ADDR_W); i++) mem_m[i] = '0;
    rd_m = '0;
  endtask

  // One complete request. BUSYWAIT must stay high for cycles 0..LATENCY and
  // drop in cycle LATENCY+1 (DONE). The model commits the operation at the
  // end of cycle LATENCY.
  // hold:     the original strobe is still asserted during DONE (stale strobe).
  // scramble: ADDRESS, WRITEDATA and the strobes are randomised during ACCESS.
  // The task returns in the IDLE cycle that follows DONE, with strobes low.
  task automatic access(input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input bit hold, input bit scramble);
    READ = !wr; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    for (int c = 0; c <= LATENCY; c++) begin
      if (c > 0 && scramble) begin
        ADDRESS   = ADDR_W'($urandom);
        WRITEDATA = DATA_W'($urandom);
        READ      = 1'($urandom);
        WRITE     = 1'($urandom);
      end
      @(negedge CLK);
      check_eq("busy_access", {31'd0, BUSYWAIT}, 32'd1);
      check_eq("rdata_hold", {24'd0, READDATA}, {24'd0, rd_m});
      step();
    end
    if (wr) mem_m[a] = d;
    else    rd_m     = mem_m[a];
    if (hold) begin
      READ = !wr; WRITE = wr;
    end else begin
      READ = 1'b0; WRITE = 1'b0;
    end
    @(negedge CLK);
    check_eq("busy_done", {31'd0, BUSYWAIT}, 32'd0);
    check_eq("rdata_done", {24'd0, READDATA}, {24'd0, rd_m});
    step();
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic idle(input int n);
    READ = 1'b0; WRITE = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check_eq("busy_idle", {31'd0, BUSYWAIT}, 32'd0);
      check_eq("rdata_idle", {24'd0, READDATA}, {24'd0, rd_m});
      step();
    end
  endtask

  // Both strobes high is illegal: no busy, no state change.
  task automatic illegal(input int n);
    READ = 1'b1; WRITE = 1'b1;
    ADDRESS = ADDR_W'($urandom); WRITEDATA = DATA_W'($urandom);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check_eq("busy_illegal", {31'd0, BUSYWAIT}, 32'd0);
      check_eq("rdata_illegal", {24'd0, READDATA}, {24'd0, rd_m});
      step();
    end
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic apply_reset();
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0;
    step();
    step();
    RESET = 1'b1;
    model_reset();
  endtask

  initial begin
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    model_reset();
    apply_reset();

    // Reset state.
    @(negedge CLK);
    check_eq("reset_busy", {31'd0, BUSYWAIT}, 32'd0);
    check_eq("reset_rdata", {24'd0, READDATA}, 32'd0);
    step();

    // Write then read back; also confirms that reset leaves an untouched word at zero.
    access(1'b1, 8'h10, 8'hA5, 1'b0, 1'b0);
    access(1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
    check_eq("t1_read_a5", {24'd0, READDATA}, 32'h0000_00A5);
    access(1'b0, 8'h77, 8'h00, 1'b0, 1'b0);
    idle(2);

    // Illegal requests for ten cycles, then confirm that memory is unchanged.
    illegal(10);
    access(1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
    check_eq("t3_mem_kept", {24'd0, READDATA}, 32'h0000_00A5);

    // Reset during ACCESS aborts the write and clears everything.
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h20; WRITEDATA = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check_eq("t4_busy", {31'd0, BUSYWAIT}, 32'd1);
      step();
    end
    RESET = 1'b0; WRITE = 1'b0;
    step();
    RESET = 1'b1;
    model_reset();
    @(negedge CLK);
    check_eq("t4_busy_after_rst", {31'd0, BUSYWAIT}, 32'd0);
    check_eq("t4_rdata_after_rst", {24'd0, READDATA}, 32'd0);
    step();
    access(1'b0, 8'h20, 8'h00, 1'b0, 1'b0);
    access(1'b0, 8'h10, 8'h00, 1'b0, 1'b0);

    // Inputs that change during ACCESS are ignored.
    access(1'b1, 8'h30, 8'h11, 1'b0, 1'b1);
    access(1'b0, 8'h30, 8'h00, 1'b0, 1'b0);
    check_eq("t5_mem30", {24'd0, READDATA}, 32'h0000_0011);
    access(1'b0, 8'h31, 8'h00, 1'b0, 1'b0);
    check_eq("t5_mem31", {24'd0, READDATA}, 32'h0000_0000);

    // Back-to-back requests at the address extremes, with stale strobes held through DONE.
    access(1'b1, 8'hFF, 8'h5A, 1'b1, 1'b0);
    access(1'b1, 8'h00, 8'h3C, 1'b1, 1'b0);
    access(1'b0, 8'hFF, 8'h00, 1'b1, 1'b0);
    check_eq("t6_read_ff", {24'd0, READDATA}, 32'h0000_005A);
    access(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    check_eq("t6_read_00", {24'd0, READDATA}, 32'h0000_003C);

    // Randomised traffic over a small address set so that reads hit earlier writes.
    for (int n = 0; n < 60; n++) begin
      int r;
      logic [ADDR_W-1:0] a;
      r = $urandom_range(0, 9);
      a = ADDR_W'($urandom_range(0, 7)) + (($urandom_range(0, 1) == 1) ? 8'hF8 : 8'h00);
      if (r == 0)      illegal($urandom_range(1, 4));
      else if (r == 1) idle($urandom_range(1, 3));
      else             access(1'($urandom), a, DATA_W'($urandom),
                              1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
